// File: rtl/surf6_bringup_pkg.sv
// Shared types for the SURF6 link bringup sequencer.
// State encoding is visible on state_o, so values are pinned.
package surf6_bringup_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      CLK_RST  = 4'd1,
      CLK_PROG = 4'd2,
      CLK_EN   = 4'd3,
      ALIGN    = 4'd4,
      EYE      = 4'd5,
      TRAIN    = 4'd6,
      MODE1    = 4'd7
   } state_t;

   localparam logic [7:0] TO_CNT_MAX = 8'd255;

endpackage

// File: rtl/surf6_flag_sync.sv
// Two-flop synchronizer for a slow level flag crossing into the local clock.
// Resets to 0 so a flag is never seen asserted straight out of reset.
module surf6_flag_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   (* ASYNC_REG = "TRUE" *) logic r_meta;
   (* ASYNC_REG = "TRUE" *) logic r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/surf6_bringup_sequencer.sv
// SURF-side link bringup: clock reset/program/enable, RXCLK align,
// eye centering and DOUT training, gated on a stable RACKCLK.
module surf6_bringup_sequencer
   import surf6_bringup_pkg::*;
#(
   parameter int RACKCLK_STABLE = 1024,
   parameter int CLK_RST_CYCLES = 64,
   parameter int CLK_EN_SETTLE  = 4096,
   parameter int HS_TIMEOUT     = 2**20,
   parameter int CNT_W          = 21
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       rackclk_ok_i,
   input  logic       mode1_ready_i,
   output logic       clk_rst_o,
   output logic       clk_prog_req_o,
   input  logic       clk_prog_done_i,
   output logic       clk_en_o,
   output logic       align_req_o,
   input  logic       align_done_i,
   output logic       eye_req_o,
   input  logic       eye_done_i,
   output logic       dout_force_low_o,
   output logic       dout_train_o,
   output logic       mode1_o,
   output logic [3:0] state_o,
   output logic [7:0] timeout_cnt_o
);

   localparam logic [CNT_W-1:0] L_STABLE = CNT_W'(RACKCLK_STABLE - 1);
   localparam logic [CNT_W-1:0] L_RST    = CNT_W'(CLK_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(CLK_EN_SETTLE - 1);
   localparam logic [CNT_W-1:0] L_HS     = CNT_W'(HS_TIMEOUT);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_prog_req;
   logic             r_align_req;
   logic             r_eye_req;
   logic [7:0]       r_to_cnt;

   state_t           w_next;
   logic [CNT_W-1:0] w_load;
   logic             w_ld;
   logic             w_dec;
   logic             w_tout;
   logic             w_rok;
   logic             w_m1;
   logic             w_zero;

   surf6_flag_sync u_rok_sync (
      .i_clk (wb_clk_i),
      .i_rst (wb_rst_i),
      .i_d   (rackclk_ok_i),
      .o_q   (w_rok)
   );

   surf6_flag_sync u_m1_sync (
      .i_clk (wb_clk_i),
      .i_rst (wb_rst_i),
      .i_d   (mode1_ready_i),
      .o_q   (w_m1)
   );

   assign w_zero = (r_cnt == '0);

   always_comb begin
      w_next = r_state;
      w_load = '0;
      w_ld   = 1'b0;
      w_dec  = 1'b0;
      w_tout = 1'b0;
      // RACKCLK loss outranks every other transition, done included
      if (r_state != IDLE && !w_rok) begin
         w_next = IDLE;
         w_ld   = 1'b1;
         w_load = L_STABLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!w_rok) begin
                  w_ld   = 1'b1;
                  w_load = L_STABLE;
               end else if (w_zero) begin
                  w_next = CLK_RST;
                  w_ld   = 1'b1;
                  w_load = L_RST;
               end else begin
                  w_dec = 1'b1;
               end
            end
            CLK_RST: begin
               if (w_zero) begin
                  w_next = CLK_PROG;
                  w_ld   = 1'b1;
                  w_load = L_HS;
               end else begin
                  w_dec = 1'b1;
               end
            end
            CLK_PROG: begin
               if (r_prog_req && clk_prog_done_i) begin
                  w_next = CLK_EN;
                  w_ld   = 1'b1;
                  w_load = L_SETTLE;
               end else if (w_zero) begin
                  w_next = IDLE;
                  w_ld   = 1'b1;
                  w_load = L_STABLE;
                  w_tout = 1'b1;
               end else begin
                  w_dec = 1'b1;
               end
            end
            CLK_EN: begin
               if (w_zero) begin
                  w_next = ALIGN;
                  w_ld   = 1'b1;
                  w_load = L_HS;
               end else begin
                  w_dec = 1'b1;
               end
            end
            ALIGN: begin
               if (r_align_req && align_done_i) begin
                  w_next = EYE;
                  w_ld   = 1'b1;
                  w_load = L_HS;
               end else if (w_zero) begin
                  w_next = IDLE;
                  w_ld   = 1'b1;
                  w_load = L_STABLE;
                  w_tout = 1'b1;
               end else begin
                  w_dec = 1'b1;
               end
            end
            EYE: begin
               if (r_eye_req && eye_done_i) begin
                  w_next = TRAIN;
               end else if (w_zero) begin
                  w_next = IDLE;
                  w_ld   = 1'b1;
                  w_load = L_STABLE;
                  w_tout = 1'b1;
               end else begin
                  w_dec = 1'b1;
               end
            end
            TRAIN: begin
               if (w_m1) begin
                  w_next = MODE1;
               end
            end
            MODE1: begin
               w_next = MODE1;
            end
            default: begin
               w_next = IDLE;
               w_ld   = 1'b1;
               w_load = L_STABLE;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_prog_req  <= 1'b0;
         r_align_req <= 1'b0;
         r_eye_req   <= 1'b0;
         r_to_cnt    <= '0;
      end else begin
         r_state <= w_next;
         if (w_ld) begin
            r_cnt <= w_load;
         end else if (w_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         // req rises one cycle after entry and drops on the exit edge
         r_prog_req  <= (r_state == CLK_PROG) && (w_next == CLK_PROG);
         r_align_req <= (r_state == ALIGN) && (w_next == ALIGN);
         r_eye_req   <= (r_state == EYE) && (w_next == EYE);
         if (w_tout && r_to_cnt != TO_CNT_MAX) begin
            r_to_cnt <= r_to_cnt + 8'd1;
         end
      end
   end

   assign clk_rst_o        = (r_state == CLK_RST);
   assign clk_prog_req_o   = r_prog_req;
   assign clk_en_o         = (r_state >= CLK_EN) && (r_state <= MODE1);
   assign align_req_o      = r_align_req;
   assign eye_req_o        = r_eye_req;
   assign dout_force_low_o = !((r_state == TRAIN) || (r_state == MODE1));
   assign dout_train_o     = (r_state == TRAIN);
   assign mode1_o          = (r_state == MODE1);
   assign state_o          = r_state;
   assign timeout_cnt_o    = r_to_cnt;

endmodule
